// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_matrix_pkg
// Description : Shared definitions for the LED matrix framebuffer clients.
//               Default memory address/data widths and the scan FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

  localparam int C_ADDRESS_WIDTH = 25;
  localparam int C_DATA_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_return_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scan_return_fifo
// Description : First-word-fall-through synchronous FIFO for read returns.
//               pop_data always shows the head entry while empty==0.
//               Simultaneous push and pop is legal at any fill level.
// Ports       : clk, reset_n      clock / asynchronous active-low reset
//               push, push_data   write strobe and word
//               pop               remove head entry (ignored when empty)
//               pop_data          head entry
//               empty, full       status flags
//               occupancy         number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_return_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_en;
  logic             w_push_en;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_DEPTH);
  assign occupancy = r_count;
  assign pop_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign w_pop_en  = pop && !empty;
  assign w_push_en = push && (!full || w_pop_en);

  // Storage needs no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_reader
// Description : Read-side framebuffer client. Walks a ROWS x COLS raster
//               from a latched base address, issues credit-limited read
//               requests to the memory arbiter, buffers the in-order returns
//               and presents them as a tagged valid/ready pixel stream.
// Ports       : clk, reset_n               clock / async active-low reset
//               enable                     run frames back-to-back while high
//               frame_base                 word address of pixel (0,0)
//               mem_address, mem_wr,       read request to arbiter
//               mem_data_in_ready          (mem_wr tied 0)
//               mem_fifo_full              arbiter ingress full
//               mem_data_out(_ready)       read return data / strobe
//               pix_data, pix_valid,       pixel stream
//               pix_ready
//               pix_row, pix_eol, pix_eof  tags of the presented pixel
//               busy                       frame in progress
// Config      : FRAME_SWAP_EN adds frame_base_alt, swap_req and bank for
//               double-buffered frame switching at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_reader
  import led_matrix_pkg::*;
#(
  parameter int ADDRESS_WIDTH = C_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = C_DATA_WIDTH,
  parameter int ROWS          = 32,
  parameter int COLS          = 64,
  parameter int BUF_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [ADDRESS_WIDTH-1:0] frame_base,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_wr,
  output logic                     mem_data_in_ready,
  input  logic                     mem_fifo_full,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_data_out_ready,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [$clog2(ROWS)-1:0]  pix_row,
  output logic                     pix_eol,
  output logic                     pix_eof,
  output logic                     busy
`ifdef FRAME_SWAP_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0] frame_base_alt,
  input  logic                     swap_req,
  output logic                     bank
`endif
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam int FW  = DATA_WIDTH + RW + 2;
  localparam logic [RW-1:0]  C_LAST_ROW = RW'(ROWS - 1);
  localparam logic [CLW-1:0] C_LAST_COL = CLW'(COLS - 1);
  localparam logic [CW:0]    C_CREDITS  = CW1'(BUF_DEPTH);

  scan_state_t r_state;
  scan_state_t w_state_next;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] w_base;
  logic [RW-1:0]            r_req_row;
  logic [CLW-1:0]           r_req_col;
  logic [RW-1:0]            r_ret_row;
  logic [CLW-1:0]           r_ret_col;
  logic [CW-1:0]            r_outstanding;
  logic                     r_eof_done;

  logic          w_frame_start;
  logic          w_credit_ok;
  logic          w_accept;
  logic          w_last_req;
  logic          w_ret;
  logic          w_pop;
  logic          w_drain_done;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_occupancy;
  logic [CW:0]   w_inflight;
  logic          w_ret_eol;
  logic          w_ret_eof;
  logic [FW-1:0] w_wr_word;
  logic [FW-1:0] w_rd_word;
  logic [FW-1:0] w_out_word;

  // --------------------------------------------------------------------------
  // Frame base selection
  // --------------------------------------------------------------------------
`ifdef FRAME_SWAP_EN
  logic r_bank;
  logic r_swap_pend;
  logic w_bank_next;

  // A request seen on the frame-start cycle itself is honoured immediately.
  assign w_bank_next = r_bank ^ (r_swap_pend | swap_req);
  assign w_base      = w_bank_next ? frame_base_alt : frame_base;
  assign bank        = r_bank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank      <= 1'b0;
      r_swap_pend <= 1'b0;
    end else if (w_frame_start) begin
      r_bank      <= w_bank_next;
      r_swap_pend <= 1'b0;
    end else if (swap_req) begin
      r_swap_pend <= 1'b1;
    end
  end
`else
  assign w_base = frame_base;
`endif

  // --------------------------------------------------------------------------
  // Credit and handshake terms
  // --------------------------------------------------------------------------
  // Every accepted request owns a buffer slot until it is popped, so the
  // buffer can never overflow regardless of arbiter return timing.
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, w_occupancy};
  assign w_credit_ok  = (w_inflight < C_CREDITS);
  assign w_accept     = mem_data_in_ready && !mem_fifo_full;
  assign w_last_req   = (r_req_row == C_LAST_ROW) && (r_req_col == C_LAST_COL);
  // Returns with nothing outstanding are stale (e.g. issued before a reset).
  assign w_ret        = mem_data_out_ready && (r_outstanding != '0);
  assign w_pop        = !w_empty && pix_ready;
  assign w_drain_done = (r_outstanding == '0) && w_empty && r_eof_done;

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_frame_start     = 1'b0;
    mem_data_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next  = FETCH;
          w_frame_start = 1'b1;
        end
      end
      FETCH: begin
        mem_data_in_ready = w_credit_ok;
        if (w_credit_ok && !mem_fifo_full && w_last_req) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_done) begin
          if (enable) begin
            w_state_next  = FETCH;
            w_frame_start = 1'b1;
          end else begin
            w_state_next  = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request side: address walks linearly because the raster is contiguous
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_req_row <= '0;
      r_req_col <= '0;
    end else if (w_frame_start) begin
      r_addr    <= w_base;
      r_req_row <= '0;
      r_req_col <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + ADDRESS_WIDTH'(1);
      if (r_req_col == C_LAST_COL) begin
        r_req_col <= '0;
        r_req_row <= (r_req_row == C_LAST_ROW) ? '0 : r_req_row + RW'(1);
      end else begin
        r_req_col <= r_req_col + CLW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_ret})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Return side: tag counters mirror the request walk (returns are in order)
  // --------------------------------------------------------------------------
  assign w_ret_eol = (r_ret_col == C_LAST_COL);
  assign w_ret_eof = w_ret_eol && (r_ret_row == C_LAST_ROW);
  assign w_wr_word = {mem_data_out, r_ret_row, w_ret_eol, w_ret_eof};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ret_row <= '0;
      r_ret_col <= '0;
    end else if (w_frame_start) begin
      r_ret_row <= '0;
      r_ret_col <= '0;
    end else if (w_ret) begin
      if (w_ret_eol) begin
        r_ret_col <= '0;
        r_ret_row <= (r_ret_row == C_LAST_ROW) ? '0 : r_ret_row + RW'(1);
      end else begin
        r_ret_col <= r_ret_col + CLW'(1);
      end
    end
  end

  scan_return_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_return_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_ret),
    .push_data (w_wr_word),
    .pop       (w_pop),
    .pop_data  (w_rd_word),
    .empty     (w_empty),
    .full      (w_full),
    .occupancy (w_occupancy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eof_done <= 1'b0;
    end else if (w_frame_start) begin
      r_eof_done <= 1'b0;
    end else if (w_pop && w_out_word[0]) begin
      r_eof_done <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: forced to zero while nothing is buffered
  // --------------------------------------------------------------------------
  assign w_out_word  = w_empty ? '0 : w_rd_word;
  assign pix_valid   = !w_empty;
  assign pix_data    = w_out_word[FW-1 -: DATA_WIDTH];
  assign pix_row     = w_out_word[RW+1:2];
  assign pix_eol     = w_out_word[1];
  assign pix_eof     = w_out_word[0];
  assign mem_address = r_addr;
  assign mem_wr      = 1'b0;
  assign busy        = (r_state != IDLE);

  ovf_check : assert property (@(posedge clk) disable iff (!reset_n)
                               !(w_ret && w_full && !w_pop))
    else $error("matrix_scan_reader: return buffer overflow");

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_reader
// Description : Self-checking bench for matrix_scan_reader. An arbiter/RAM
//               model answers accepted reads after a fixed latency; a
//               reference model predicts each frame's addresses and tagged
//               pixels, which a separate monitor compares on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_reader;

  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int ROWS  = 2;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int N     = ROWS * COLS;
  localparam int LAT   = 4;
  localparam int RW    = $clog2(ROWS);

  typedef logic [DW+RW+1:0] pix_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic [AW-1:0] mem_address;
  logic          mem_wr;
  logic          mem_data_in_ready;
  logic          mem_fifo_full = 1'b0;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_data_out_ready = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [RW-1:0] pix_row;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
`ifdef FRAME_SWAP_EN
  logic [AW-1:0] frame_base_alt = '0;
  logic          swap_req = 1'b0;
  logic          bank;
`endif

  always #5 clk = ~clk;

  matrix_scan_reader #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .ROWS          (ROWS),
    .COLS          (COLS),
    .BUF_DEPTH     (DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .frame_base         (frame_base),
    .mem_address        (mem_address),
    .mem_wr             (mem_wr),
    .mem_data_in_ready  (mem_data_in_ready),
    .mem_fifo_full      (mem_fifo_full),
    .mem_data_out       (mem_data_out),
    .mem_data_out_ready (mem_data_out_ready),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_row            (pix_row),
    .pix_eol            (pix_eol),
    .pix_eof            (pix_eof),
    .busy               (busy)
`ifdef FRAME_SWAP_EN
    ,
    .frame_base_alt     (frame_base_alt),
    .swap_req           (swap_req),
    .bank               (bank)
`endif
  );

  // --------------------------------------------------------------------------
  // Bookkeeping and reference model state
  // --------------------------------------------------------------------------
  int test_cnt  = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  int acc_idx   = 0;
  int acc_total = 0;
  int pop_cnt   = 0;
  int rdy_mode  = 1;   // 0: pix_ready low, 1: high, 2: random
  int full_mode = 0;   // 0: never full, 1: full 1-in-3, 2: random

  logic          m_bank = 1'b0;
  logic          m_swap_pend = 1'b0;
  logic [AW-1:0] m_base = '0;

  logic [DW-1:0] ram [logic [AW-1:0]];
  logic [AW-1:0] pend_addr [$];
  int            pend_due  [$];
  pix_t          exp_q     [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] get_ram(input logic [AW-1:0] a);
    if (!ram.exists(a)) ram[a] = DW'($urandom);
    return ram[a];
  endfunction

  // Raster order: word idx sits at base+idx, row idx/COLS, column idx%COLS.
  task automatic model_accept();
    logic [AW-1:0] exp_addr;
    pix_t          px;
    int            idx;
    idx = acc_idx;
    if (idx == 0) begin
`ifdef FRAME_SWAP_EN
      if (m_swap_pend) begin
        m_bank      = ~m_bank;
        m_swap_pend = 1'b0;
      end
      m_base = m_bank ? frame_base_alt : frame_base;
      check("bank_at_frame_start", 64'(bank), 64'(m_bank));
`else
      m_base = frame_base;
`endif
    end
    exp_addr = m_base + AW'(idx);
    check("req_address", 64'(mem_address), 64'(exp_addr));
    pend_addr.push_back(mem_address);
    pend_due.push_back(cyc + LAT);
    px = {get_ram(exp_addr), RW'(idx / COLS), (idx % COLS) == (COLS - 1), idx == (N - 1)};
    exp_q.push_back(px);
    acc_idx = (idx + 1) % N;
    acc_total++;
  endtask

  // --------------------------------------------------------------------------
  // Arbiter + RAM model and downstream ready driver
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    case (full_mode)
      0:       mem_fifo_full = 1'b0;
      1:       mem_fifo_full = (cyc % 3 == 0);
      default: mem_fifo_full = ($urandom_range(0, 3) == 0);
    endcase
    case (rdy_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_data_out_ready = 1'b1;
      mem_data_out       = get_ram(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_data_out_ready = 1'b0;
      mem_data_out       = DW'($urandom);
    end
    #1;
    if (reset_n && mem_data_in_ready && !mem_fifo_full) model_accept();
  end

  // --------------------------------------------------------------------------
  // Pixel monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    pix_t got;
    pix_t exp;
    #1;
    if (reset_n && pix_valid && pix_ready) begin
      pop_cnt++;
      got = {pix_data, pix_row, pix_eol, pix_eof};
      if (exp_q.size() == 0) begin
        check("pixel_unexpected", 64'(got), 64'(0));
        if (got == '0) begin
          fail_cnt++;
          $display("FAIL pixel_unexpected: got 0x0 with no pixel expected");
        end
      end else begin
        exp = exp_q.pop_front();
        check("pixel", 64'(got), 64'(exp));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", 64'(n < budget), 64'(1));
    check("busy_fell_after_eof", 64'(exp_q.size()), 64'(0));
    check("idle_pix_valid", 64'(pix_valid), 64'(0));
  endtask

  task automatic start_frame();
    int n;
    n = 0;
    enable = 1'b1;
    do begin
      step();
      n++;
    end while (!busy && n < 10);
    check("frame_started", 64'(busy), 64'(1));
  endtask

  task automatic run_frame(input int budget);
    int a0;
    a0 = acc_total;
    start_frame();
    enable = 1'b0;
    wait_idle(budget);
    check("frame_accepts", 64'(acc_total - a0), 64'(N));
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int a0;
    int p0;
    int n;
    int gaps;
    bit seen;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_mem_address", 64'(mem_address), 64'(0));
    check("rst_req_ready", 64'(mem_data_in_ready), 64'(0));
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_pix_outputs", 64'({pix_valid, pix_data, pix_row, pix_eol, pix_eof}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    step();

    // Plain frame, no back-pressure anywhere.
    rdy_mode   = 1;
    full_mode  = 0;
    frame_base = AW'('h100);
    run_frame(200);

    // Downstream stall: credits must cap in-flight words at DEPTH.
    a0 = acc_total;
    p0 = pop_cnt;
    rdy_mode = 0;
    start_frame();
    enable = 1'b0;
    repeat (40) step();
    check("stall_inflight", 64'((acc_total - a0) - (pop_cnt - p0)), 64'(DEPTH));
    check("stall_req_ready", 64'(mem_data_in_ready), 64'(0));
    rdy_mode = 1;
    wait_idle(200);
    check("stall_frame_accepts", 64'(acc_total - a0), 64'(N));

    // Arbiter full 1-in-3: same addresses, same data.
    full_mode = 1;
    run_frame(300);
    full_mode = 0;

    // enable dropped after word 3: frame completes, nothing more is issued.
    a0 = acc_total;
    enable = 1'b1;
    n = 0;
    while (acc_total - a0 < 3 && n < 50) begin
      step();
      n++;
    end
    enable = 1'b0;
    wait_idle(200);
    check("drop_frame_accepts", 64'(acc_total - a0), 64'(N));
    repeat (20) step();
    check("drop_no_new_requests", 64'(acc_total - a0), 64'(N));
    check("drop_stays_idle", 64'(busy), 64'(0));

    // enable held: two frames with busy never dropping in between.
    a0   = acc_total;
    gaps = 0;
    seen = 1'b0;
    n    = 0;
    enable = 1'b1;
    while (acc_total - a0 < 2 * N && n < 300) begin
      step();
      n++;
      if (busy) seen = 1'b1;
      else if (seen) gaps++;
    end
    enable = 1'b0;
    wait_idle(200);
    check("b2b_accepts", 64'(acc_total - a0), 64'(2 * N));
    check("b2b_idle_gaps", 64'(gaps), 64'(0));

    // Reset with reads in flight: late returns must be dropped.
    frame_base = AW'('h300);
    enable = 1'b1;
    n = 0;
    while (pend_due.size() < 3 && n < 50) begin
      step();
      n++;
    end
    check("reset_inflight_reached", 64'(pend_due.size() >= 3), 64'(1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    acc_idx = 0;
    exp_q.delete();
    m_bank      = 1'b0;
    m_swap_pend = 1'b0;
    #1;
    check("reset_now_outputs",
          64'({mem_data_in_ready, busy, pix_valid, pix_data, mem_address}), 64'(0));
    step();
    reset_n = 1'b1;
    n = 0;
    gaps = 0;
    while (pend_due.size() > 0 && n < 30) begin
      step();
      n++;
      if (pix_valid) gaps++;
    end
    step();
    if (pix_valid) gaps++;
    check("late_returns_dropped", 64'(gaps), 64'(0));
    run_frame(200);

    // Randomized frames, including a base that wraps the address space.
    for (int k = 0; k < 6; k++) begin
      full_mode  = 2;
      rdy_mode   = 2;
      frame_base = (k == 0) ? {AW{1'b1}} - AW'(2) : AW'($urandom);
      run_frame(600);
    end
    full_mode = 0;
    rdy_mode  = 1;

`ifdef FRAME_SWAP_EN
    // Swap requested mid-frame takes effect only at the next frame start.
    frame_base     = AW'('h200);
    frame_base_alt = AW'('h800);
    a0 = acc_total;
    start_frame();
    enable = 1'b0;
    n = 0;
    while (acc_total - a0 < 3 && n < 50) begin
      step();
      n++;
    end
    swap_req    = 1'b1;
    m_swap_pend = 1'b1;
    step();
    swap_req = 1'b0;
    check("bank_mid_frame", 64'(bank), 64'(0));
    wait_idle(200);
    check("bank_after_frame", 64'(bank), 64'(0));
    run_frame(200);
    check("bank_swapped", 64'(bank), 64'(1));
`endif

    repeat (5) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", test_cnt);
    $fatal(1, "watchdog timeout");
  end

endmodule
`default_nettype wire
